// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the memory-mapped UART transmitter:
//   FSM state encoding, register offsets (addr[3:2]) and STATUS bit indices.
//   ST_PARITY is only reachable when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Register offsets, word index taken from addr[3:2]
  localparam logic [1:0] TXDATA_OFF = 2'd0;
  localparam logic [1:0] STATUS_OFF = 2'd1;
  localparam logic [1:0] DIV_OFF    = 2'd2;

  // STATUS register bit positions
  localparam int unsigned ST_FULL_BIT  = 0;
  localparam int unsigned ST_EMPTY_BIT = 1;
  localparam int unsigned ST_BUSY_BIT  = 2;
  localparam int unsigned ST_OVF_BIT   = 3;
  localparam int unsigned ST_PAR_BIT   = 4;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with synchronous active-high reset. Contents are not
//   cleared by reset; only pointers and count are.
//   Parameters: WIDTH (data width), DEPTH (entries, power of two, >= 2).
//   Ports:
//     clk, reset   clock / synchronous active-high reset
//     push, din    write strobe and data; accepted when not full, or when a
//                  pop happens in the same cycle
//     pop, dout    read strobe (ignored when empty) and head-of-queue data
//     full, empty  occupancy flags
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  // A pop frees the slot this cycle, so a full FIFO can still take a push
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter on the core data-memory port.
//   Register window: BASE_ADDR[31:4], offset addr[3:2]:
//     0x0 TXDATA (W)  push wdata[7:0] into the TX FIFO
//     0x4 STATUS (R)  {par_en, overflow, busy, empty, full}; write bit3=1 clears overflow
//     0x8 DIV    (RW) baud divisor (cycles/bit), 0 is stored as 1
//     0xC reserved
//   Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after DATA.
//   Ports:
//     clk, reset  clock / synchronous active-high reset
//     addr, wdata core address and store data; we = store strobe
//     rdata       combinational read data, 0 when not selected
//     sel_out     combinational window match, used by the SoC read mux
//     tx_out      serial line, idle high
//     irq_out     registered: FIFO empty and FSM idle
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        sel_out,
  output logic        tx_out,
  output logic        irq_out
);

  logic [1:0]  w_off;
  logic        w_wr;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [7:0]  w_fifo_dout;
  logic        w_drop;
  logic        w_bit_done;
  logic [31:0] w_status;
  logic        w_tx;
  logic        w_unused;

  logic [15:0] r_div;
  logic [15:0] r_bit_div;
  logic [15:0] r_timer;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shift;
  logic        r_ovf;
  logic        r_irq;
`ifdef UART_TX_PARITY_EN
  logic        r_par;
`endif

  tx_state_t r_state;
  tx_state_t w_next;

  assign w_unused = &{1'b0, addr[1:0], wdata[31:16]};

  // ---------------- decode ----------------
  assign sel_out = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_off   = addr[3:2];
  assign w_wr    = we && sel_out;
  assign w_push  = w_wr && (w_off == TXDATA_OFF);
  assign w_drop  = w_push && w_full && !w_pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (wdata[7:0]),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= 16'(CLK_DIV);
      r_ovf <= 1'b0;
      r_irq <= 1'b1;
    end else begin
      if (w_wr && (w_off == DIV_OFF)) begin
        r_div <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_wr && (w_off == STATUS_OFF) && wdata[ST_OVF_BIT]) begin
        r_ovf <= 1'b0;
      end
      r_irq <= w_empty && (r_state == ST_IDLE);
    end
  end

  assign irq_out = r_irq;

  always_comb begin
    w_status               = '0;
    w_status[ST_FULL_BIT]  = w_full;
    w_status[ST_EMPTY_BIT] = w_empty;
    w_status[ST_BUSY_BIT]  = (r_state != ST_IDLE);
    w_status[ST_OVF_BIT]   = r_ovf;
`ifdef UART_TX_PARITY_EN
    w_status[ST_PAR_BIT]   = 1'b1;
`endif
  end

  always_comb begin
    rdata = '0;
    if (sel_out) begin
      case (w_off)
        STATUS_OFF: rdata = w_status;
        DIV_OFF:    rdata = {16'h0000, r_div};
        default:    rdata = '0;
      endcase
    end
  end

  // ---------------- FSM ----------------
  assign w_bit_done = (r_timer == 16'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (!w_empty) w_next = ST_START;
      ST_START: if (w_bit_done) w_next = ST_DATA;
      ST_DATA: begin
        if (w_bit_done && (r_bitcnt == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          w_next = ST_PARITY;
`else
          w_next = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (w_bit_done) w_next = ST_STOP;
`endif
      ST_STOP:  if (w_bit_done) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pop = (r_state == ST_IDLE) && !w_empty;
    case (r_state)
      ST_START: w_tx = 1'b0;
      ST_DATA:  w_tx = r_shift[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_tx = r_par;
`endif
      default:  w_tx = 1'b1;
    endcase
  end

  assign tx_out = w_tx;

  // Bit timer and shifter. The divisor is snapshotted into r_bit_div on pop,
  // so DIV writes during a frame only take effect on the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer   <= '0;
      r_bit_div <= 16'(CLK_DIV);
      r_bitcnt  <= '0;
      r_shift   <= '0;
`ifdef UART_TX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else if (w_pop) begin
      r_shift   <= w_fifo_dout;
      r_bit_div <= r_div;
      r_timer   <= r_div - 16'd1;
      r_bitcnt  <= '0;
`ifdef UART_TX_PARITY_EN
      r_par     <= ^w_fifo_dout;
`endif
    end else if (r_state != ST_IDLE) begin
      if (w_bit_done) begin
        r_timer <= r_bit_div - 16'd1;
        if (r_state == ST_DATA) begin
          r_shift  <= {1'b0, r_shift[7:1]};
          r_bitcnt <= r_bitcnt + 3'd1;
        end
      end else begin
        r_timer <= r_timer - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] A_TX  = BASE + 32'h0;
  localparam logic [31:0] A_ST  = BASE + 32'h4;
  localparam logic [31:0] A_DIV = BASE + 32'h8;
  localparam logic [31:0] A_RSV = BASE + 32'hC;
`ifdef UART_TX_PARITY_EN
  localparam logic [31:0] PAR_ST = 32'h10;
`else
  localparam logic [31:0] PAR_ST = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        sel_out;
  logic        tx_out;
  logic        irq_out;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  mmio_uart_tx dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .wdata   (wdata),
    .we      (we),
    .rdata   (rdata),
    .sel_out (sel_out),
    .tx_out  (tx_out),
    .irq_out (irq_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a;
    #1 d = rdata;
  endtask

  // Waits for the start bit, then checks every cycle of the frame plus one
  // trailing high cycle. lat = negedges waited until the start bit appeared.
  task automatic expect_frame(input logic [7:0] b, input int unsigned div,
                              output int unsigned lat);
    logic [10:0] exp_bits;
    int unsigned nb;
`ifdef UART_TX_PARITY_EN
    nb       = 11;
    exp_bits = {1'b1, ^b, b, 1'b0};
`else
    nb       = 10;
    exp_bits = {1'b1, 1'b1, b, 1'b0};
`endif
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (tx_out !== 1'b0 && lat < 2000);
    if (tx_out !== 1'b0) begin
      chk($sformatf("start_timeout_0x%02h", b), {31'h0, tx_out}, 32'h0);
      return;
    end
    for (int unsigned i = 0; i < nb * div; i++) begin
      if (i != 0) @(negedge clk);
      chk($sformatf("frame_0x%02h_bit%0d", b, i / div), {31'h0, tx_out},
          {31'h0, exp_bits[i / div]});
    end
    @(negedge clk);
    chk($sformatf("frame_0x%02h_end", b), {31'h0, tx_out}, 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int unsigned lat;
    int unsigned lows;

    reset = 1'b1;
    addr  = 32'h0;
    wdata = 32'h0;
    we    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state and decode
    chk("rst_tx", {31'h0, tx_out}, 32'h1);
    chk("rst_irq", {31'h0, irq_out}, 32'h1);
    bus_read(A_ST, d);  chk("rst_status", d, 32'h2 | PAR_ST);
    bus_read(A_DIV, d); chk("rst_div", d, 32'd868);
    bus_read(A_TX, d);  chk("txdata_read", d, 32'h0);
    bus_read(A_RSV, d); chk("reserved_read", d, 32'h0);
    chk("sel_in", {31'h0, sel_out}, 32'h1);
    bus_read(BASE + 32'h14, d);
    chk("sel_out_of_window", {31'h0, sel_out}, 32'h0);
    chk("rdata_unselected", d, 32'h0);

    // Single frame, DIV=4, 0xA5
    bus_write(A_DIV, 32'd4);
    bus_read(A_DIV, d); chk("div4", d, 32'd4);
    bus_write(A_TX, 32'hA5);
    expect_frame(8'hA5, 4, lat);
    chk("start_latency", lat, 32'd1);
    repeat (2) @(negedge clk);
    chk("irq_after_frame", {31'h0, irq_out}, 32'h1);
    bus_read(A_ST, d); chk("status_after_frame", d, 32'h2 | PAR_ST);

    // Burst of 10 at DIV=2: 9 accepted, 10th dropped, overflow sticky/clear
    bus_write(A_DIV, 32'd2);
    fork
      begin
        int unsigned lm;
        int unsigned lw;
        for (int unsigned k = 0; k < 9; k++) begin
          expect_frame(8'(8'h30 + k), 2, lm);
        end
        lw = 0;
        repeat (40) begin
          @(negedge clk);
          if (tx_out == 1'b0) lw++;
        end
        chk("no_tenth_frame", lw, 32'd0);
      end
      begin
        logic [31:0] s;
        @(negedge clk);
        addr = A_TX;
        we   = 1'b1;
        for (int unsigned k = 0; k < 10; k++) begin
          wdata = 32'h30 + k;
          @(negedge clk);
        end
        we   = 1'b0;
        addr = A_ST;
        #1 s = rdata;
        chk("status_after_burst", s, 32'hD | PAR_ST);
        bus_write(A_ST, 32'h8);
        bus_read(A_ST, s);
        chk("ovf_cleared", s & 32'h8, 32'h0);
      end
    join

    // DIV=0 stores 1
    bus_write(A_DIV, 32'd0);
    bus_read(A_DIV, d); chk("div0_reads1", d, 32'd1);
    bus_write(A_TX, 32'h3C);
    expect_frame(8'h3C, 1, lat);
    chk("div1_latency", lat, 32'd1);

    // DIV change mid-frame applies to the next frame only
    bus_write(A_DIV, 32'd3);
    fork
      begin
        int unsigned lm;
        expect_frame(8'h55, 3, lm);
        expect_frame(8'h0F, 5, lm);
      end
      begin
        bus_write(A_TX, 32'h55);
        bus_write(A_TX, 32'h0F);
        repeat (4) @(negedge clk);
        bus_write(A_DIV, 32'd5);
      end
    join

    // Reset during DATA with 3 bytes queued
    bus_write(A_DIV, 32'd4);
    bus_write(A_TX, 32'h11);
    bus_write(A_TX, 32'h22);
    bus_write(A_TX, 32'h33);
    bus_write(A_TX, 32'h44);
    repeat (3) @(negedge clk);
    bus_read(A_ST, d); chk("status_mid_frame", d, 32'h4 | PAR_ST);
    chk("irq_mid_frame", {31'h0, irq_out}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("tx_after_reset", {31'h0, tx_out}, 32'h1);
    reset = 1'b0;
    bus_read(A_ST, d);  chk("status_after_reset", d, 32'h2 | PAR_ST);
    bus_read(A_DIV, d); chk("div_after_reset", d, 32'd868);
    chk("irq_after_reset", {31'h0, irq_out}, 32'h1);
    lows = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_out == 1'b0) lows++;
    end
    chk("queue_discarded", lows, 32'd0);

    // Odd-weight byte: parity bit 1 when parity is enabled
    bus_write(A_DIV, 32'd3);
    bus_write(A_TX, 32'h07);
    expect_frame(8'h07, 3, lat);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
